// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_e : arbiter sequencer states
//   owner_e : which requester owns the current transaction
//   DEPTH_DEF : default number of valid memory words
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam int DEPTH_DEF = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req_i[0]     : port A request
//   req_i[1]     : port B request
//   last_owner_i : port granted most recently
//   valid_o      : at least one request present
//   owner_o      : winning port (meaningful only with valid_o)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output logic       valid_o,
  output owner_e     owner_o
);

  always_comb begin
    valid_o = |req_i;
    owner_o = OWN_A;
    if (req_i == 2'b11) begin
      // Tie: hand the grant to whoever did not go last.
      owner_o = (last_owner_i == OWN_A) ? OWN_B : OWN_A;
    end else if (req_i[1]) begin
      owner_o = OWN_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port data memory
// with one cycle of registered read latency.
//   CLK, RESET          : clock (rising edge), asynchronous active-high reset
//   A_* / B_*           : requester ports (REQ level, WE, ADDR, WDATA in;
//                         ACK pulse, ERR, RDATA out)
//   M_*                 : memory strobes, address, write data, read data
//   BUSY                : high while a transaction is in ISSUE or DONE
// Each transaction takes IDLE -> ISSUE -> DONE; addresses >= DEPTH never
// strobe the memory and complete with ERR set.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic              A_ERR,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic              B_ERR,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              M_MEMREAD,
  output logic              M_MEMWRITE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WRITE_DATA,
  input  logic [DATA_W-1:0] M_READ_DATA,
  output logic              BUSY
);

  // Full-width limit so high address bits are never truncated away.
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            owner_q, owner_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic              b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic              busy_q, busy_d;

  logic              gnt_valid;
  owner_e            gnt_owner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_in_range;

  rr_arb2 u_rr_arb2 (
    .req_i        ({B_REQ, A_REQ}),
    .last_owner_i (last_owner_q),
    .valid_o      (gnt_valid),
    .owner_o      (gnt_owner)
  );

  always_comb begin
    win_we       = (gnt_owner == OWN_B) ? B_WE    : A_WE;
    win_addr     = (gnt_owner == OWN_B) ? B_ADDR  : A_ADDR;
    win_wdata    = (gnt_owner == OWN_B) ? B_WDATA : A_WDATA;
    win_in_range = (win_addr < DEPTH_LIM);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_B;
      owner_q      <= OWN_A;
      err_q        <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
      busy_q       <= busy_d;
    end
  end

  // Output registers are loaded on the edge entering the state in which
  // they must be visible, so ISSUE and DONE each see their values directly.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    err_d        = err_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    m_addr_d     = '0;
    m_wdata_d    = '0;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    busy_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = ISSUE;
          owner_d      = gnt_owner;
          last_owner_d = gnt_owner;
          err_d        = !win_in_range;
          mem_wr_d     = win_in_range && win_we;
          mem_rd_d     = win_in_range && !win_we;
          m_addr_d     = win_addr;
          m_wdata_d    = win_wdata;
          busy_d       = 1'b1;
        end
      end
      ISSUE: begin
        state_d = DONE;
        busy_d  = 1'b1;
        a_ack_d = (owner_q == OWN_A);
        a_err_d = (owner_q == OWN_A) && err_q;
        b_ack_d = (owner_q == OWN_B);
        b_err_d = (owner_q == OWN_B) && err_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign M_MEMREAD    = mem_rd_q;
  assign M_MEMWRITE   = mem_wr_q;
  assign M_ADDR       = m_addr_q;
  assign M_WRITE_DATA = m_wdata_q;
  assign BUSY         = busy_q;
  assign A_ACK        = a_ack_q;
  assign A_ERR        = a_err_q;
  assign B_ACK        = b_ack_q;
  assign B_ERR        = b_err_q;

  // The memory's own output register only becomes valid in DONE, so read
  // data is steered straight through, gated by the registered ACK/ERR.
  assign A_RDATA = (a_ack_q && !a_err_q) ? M_READ_DATA : '0;
  assign B_RDATA = (b_ack_q && !b_err_q) ? M_READ_DATA : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [31:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
  logic        A_ACK, A_ERR, B_ACK, B_ERR;
  logic [31:0] A_RDATA, B_RDATA;
  logic        M_MEMREAD, M_MEMWRITE;
  logic [31:0] M_ADDR, M_WRITE_DATA, M_READ_DATA;
  logic        BUSY;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_ACK(A_ACK), .A_ERR(A_ERR), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_ACK(B_ACK), .B_ERR(B_ERR), .B_RDATA(B_RDATA),
    .M_MEMREAD(M_MEMREAD), .M_MEMWRITE(M_MEMWRITE), .M_ADDR(M_ADDR),
    .M_WRITE_DATA(M_WRITE_DATA), .M_READ_DATA(M_READ_DATA), .BUSY(BUSY)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Memory behind the arbiter: registered read, write echoes WRITE_DATA.
  logic [31:0] mem [0:31];
  logic        preload;
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      M_READ_DATA <= '0;
    end else if (M_MEMWRITE && M_ADDR < 32) begin
      mem[M_ADDR[4:0]] <= M_WRITE_DATA;
      M_READ_DATA      <= M_WRITE_DATA;
    end else if (M_MEMREAD && M_ADDR < 32) begin
      M_READ_DATA <= mem[M_ADDR[4:0]];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  typedef struct {
    bit          port;   // 0 = A, 1 = B
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [0:31];

  // Build the expected completion for one access and queue it.
  task automatic expect_txn(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int at_cyc);
    exp_t e;
    e.port = port;
    e.err  = (addr >= 32);
    e.cyc  = at_cyc;
    if (e.err)   e.rdata = '0;
    else if (we) e.rdata = wdata;
    else         e.rdata = ref_mem[addr[4:0]];
    if (we && !e.err) ref_mem[addr[4:0]] = wdata;
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin B_REQ = req; B_WE = we; B_ADDR = addr; B_WDATA = wdata; end
    else      begin A_REQ = req; A_WE = we; A_ADDR = addr; A_WDATA = wdata; end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Single transaction from one port; checks the memory strobes in ISSUE.
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit err;
    err = (addr >= 32);
    drive(port, 1'b1, we, addr, wdata);
    expect_txn(port, we, addr, wdata, cyc + 2);
    step(1);
    chk("issue_wr", M_MEMWRITE, we && !err);
    chk("issue_rd", M_MEMREAD, !we && !err);
    if (!err) chk("issue_addr", M_ADDR, addr);
    if (we && !err) chk("issue_wdata", M_WRITE_DATA, wdata);
    chk("issue_busy", BUSY, 1);
    step(1);
    chk("done_strobes", {M_MEMREAD, M_MEMWRITE}, 0);
    drive(port, 1'b0, 1'b0, '0, '0);
    step(1);
    chk("idle_busy", BUSY, 0);
  endtask

  // Scoreboard side: every ACK pops one expectation.
  always @(negedge CLK) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      chk("missing_ack", 64'(cyc), 64'(mon_e.cyc));
    end
    if (A_ACK || B_ACK) begin
      chk("one_ack", A_ACK & B_ACK, 0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_port", B_ACK, mon_e.port);
        chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("ack_err", B_ACK ? B_ERR : A_ERR, mon_e.err);
        chk("ack_rdata", B_ACK ? B_RDATA : A_RDATA, mon_e.rdata);
        chk("nonowner_zero", B_ACK ? {A_ERR, |A_RDATA} : {B_ERR, |B_RDATA}, 0);
        $display("txn port=%s err=%0d rdata=0x%08h cycle=%0d",
                 B_ACK ? "B" : "A", B_ACK ? B_ERR : A_ERR,
                 B_ACK ? B_RDATA : A_RDATA, cyc);
      end
    end else begin
      chk("idle_resp_zero", {A_ERR, B_ERR, |A_RDATA, |B_RDATA}, 0);
    end
  end

  initial begin
    int c;
    RESET = 1'b1;
    preload = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    step(2);
    chk("reset_outputs", |{A_ACK, A_ERR, A_RDATA, B_ACK, B_ERR, B_RDATA, M_MEMREAD,
                           M_MEMWRITE, M_ADDR, M_WRITE_DATA, BUSY}, 0);
    preload = 1'b0;
    RESET   = 1'b0;
    step(1);

    // Write then read back on port A; boundary address 31 on port B.
    do_txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b0, 32'd5, 32'h0);
    do_txn(1'b1, 1'b1, 32'd31, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b0, 32'd31, 32'h0);

    // Simultaneous requests, held: A, B, A, B.
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'd7, 32'h0000_1234);
    expect_txn(1'b0, 1'b0, 32'd3, 32'h0, c + 2);
    expect_txn(1'b1, 1'b1, 32'd7, 32'h0000_1234, c + 5);
    expect_txn(1'b0, 1'b0, 32'd3, 32'h0, c + 8);
    expect_txn(1'b1, 1'b1, 32'd7, 32'h0000_1234, c + 11);
    step(8);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step(3);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step(1);
    do_txn(1'b0, 1'b0, 32'd7, 32'h0);

    // Out-of-range: just past the top, far past the top, and a write.
    do_txn(1'b1, 1'b0, 32'd32, 32'h0);
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    do_txn(1'b0, 1'b1, 32'd33, 32'h5555_AAAA);

    // Reset in the middle of an A write to address 2.
    drive(1'b0, 1'b1, 1'b1, 32'd2, 32'hAAAA_5555);
    step(1);
    chk("pre_reset_wr", M_MEMWRITE, 1);
    #2 RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1 chk("async_reset_zero", |{A_ACK, A_ERR, A_RDATA, B_ACK, B_ERR, B_RDATA, M_MEMREAD,
                                  M_MEMWRITE, M_ADDR, M_WRITE_DATA, BUSY}, 0);
    step(2);
    RESET = 1'b0;
    step(1);
    // Last grant was A, so only a reset lets A win this tie.
    c = cyc;
    drive(1'b0, 1'b1, 1'b0, 32'd2, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
    expect_txn(1'b0, 1'b0, 32'd2, 32'h0, c + 2);
    expect_txn(1'b1, 1'b0, 32'd2, 32'h0, c + 5);
    step(2);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step(3);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step(1);

    // Back-to-back on A with REQ held across the first ACK.
    c = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'd10, 32'h1111_2222);
    expect_txn(1'b0, 1'b1, 32'd10, 32'h1111_2222, c + 2);
    expect_txn(1'b0, 1'b1, 32'd11, 32'h3333_4444, c + 5);
    step(1);
    chk("b2b_busy1", BUSY, 1);
    step(1);
    chk("b2b_busy2", BUSY, 1);
    drive(1'b0, 1'b1, 1'b1, 32'd11, 32'h3333_4444);
    step(1);
    chk("b2b_busy3_idle", BUSY, 0);
    step(1);
    chk("b2b_busy4", BUSY, 1);
    chk("b2b_addr", M_ADDR, 32'd11);
    step(1);
    chk("b2b_busy5", BUSY, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step(1);
    chk("b2b_busy6_idle", BUSY, 0);
    do_txn(1'b1, 1'b0, 32'd10, 32'h0);
    do_txn(1'b1, 1'b0, 32'd11, 32'h0);

    step(3);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer in front of the single-port data memory (32 x 32-bit, registered read, 1-cycle latency).
- Port A is the CPU MEM stage; port B is the debug/DMA loader.
- Serialises accesses, drives the memory's MEMREAD/MEMWRITE/ADDR/WRITE_DATA, returns read data with a one-cycle ACK, and rejects out-of-range addresses.

Parameters:
- DATA_W, 32, data width
- ADDR_W, 32, requester/memory address width
- DEPTH, 32, number of valid memory words; address >= DEPTH is an error

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-high
- A_REQ  in  1  port A request, level, held until A_ACK
- A_WE  in  1  port A 1=write, 0=read
- A_ADDR  in  ADDR_W  port A word address
- A_WDATA  in  DATA_W  port A write data
- A_ACK  out  1  port A completion, one-cycle pulse
- A_ERR  out  1  port A address error, valid with A_ACK
- A_RDATA  out  DATA_W  port A read data, valid with A_ACK
- B_REQ, B_WE, B_ADDR, B_WDATA, B_ACK, B_ERR, B_RDATA: same as port A, for port B
- M_MEMREAD  out  1  to memory MEMREAD
- M_MEMWRITE  out  1  to memory MEMWRITE
- M_ADDR  out  ADDR_W  to memory ADDR
- M_WRITE_DATA  out  DATA_W  to memory WRITE_DATA
- M_READ_DATA  in  DATA_W  from memory READ_DATA, registered by the memory
- BUSY  out  1  high in ISSUE and DONE

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; last_owner = B, so A wins the first tie.
  - All outputs 0; any in-flight transaction is dropped with no ACK.
- States: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE:
  - Sample A_REQ and B_REQ.
  - If exactly one is high, grant it. If both are high, grant the port that is not last_owner.
  - Latch the winner's WE, ADDR and WDATA into owner/op/addr/wdata registers, set last_owner = winner, go to ISSUE.
  - If neither request is high, stay in IDLE.
- ISSUE (exactly one cycle):
  - M_ADDR and M_WRITE_DATA = latched values.
  - If addr < DEPTH: M_MEMWRITE = op, M_MEMREAD = !op.
  - If addr >= DEPTH: both strobes held 0 and the err flag is set.
  - Next state DONE.
- DONE (exactly one cycle):
  - Strobes are 0; the memory's READ_DATA is now valid.
  - Owner's ACK = 1. Owner's RDATA = M_READ_DATA, or 0 if err. Owner's ERR = err.
  - The memory returns WRITE_DATA on writes, so a write ACK carries the written value.
  - Next state IDLE, unconditionally.
- Non-owner outputs:
  - ACK, ERR and RDATA of the non-owning port stay 0.
  - Outside DONE, all ACK/ERR/RDATA are 0.
- Latency and throughput:
  - REQ seen at edge k, ACK high in cycle k+2.
  - Maximum throughput is one transaction per 3 cycles.
- Requester rule:
  - Deassert REQ on the edge that ends the ACK cycle, unless issuing a back-to-back transaction.
  - REQ still high in the following IDLE cycle is treated as a new request.
- Request changes:
  - Changes to a non-granted port's REQ/ADDR/WDATA during ISSUE/DONE have no effect; they are re-sampled in IDLE.
  - Deasserting a granted REQ mid-transaction does not abort it.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B. No port waits more than one transaction.
- Width rules: ADDR compared unsigned against DEPTH across the full ADDR_W. No truncation before the check.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, ISSUE, DONE}
  - owner encoding {OWN_A = 0, OWN_B = 1}
  - DEPTH default constant
- One sub-module, rr_arb2: 2-way round-robin grant from req[1:0] and last_owner. Purely combinational, under 30 lines. The FSM stays in dmem_arbiter.

Test Plan:
- Write, then read:
  - A writes 0xDEADBEEF to addr 5 (REQ at edge 0) -> M_MEMWRITE=1, M_ADDR=5 in cycle 1; A_ACK=1, A_RDATA=0xDEADBEEF in cycle 2; B outputs 0.
  - Then A reads addr 5 -> M_MEMREAD=1 in cycle 1; A_ACK with A_RDATA=0xDEADBEEF, A_ERR=0.
- Simultaneous requests from reset: A reads 3, B writes 0x1234 to 7, both REQ held -> A granted first (ACK cycle 2), B second (ACK cycle 5); continuing both requests gives the order A, B, A, B.
- Out-of-range access: B reads addr 32 and, separately, addr 0x80000000 -> M_MEMREAD and M_MEMWRITE stay 0 throughout; B_ACK=1, B_ERR=1, B_RDATA=0 in cycle 2.
- Reset mid-operation: assert RESET asynchronously during ISSUE of an A write to addr 2 -> all outputs 0 immediately; no A_ACK; next transaction starts cleanly from IDLE with A winning the tie.
- Back-to-back requests from one port: A keeps REQ high across its ACK with a new address -> a second transaction begins in the following IDLE, ACKs are 3 cycles apart, and BUSY is low only in the IDLE cycles.
